// File: rtl/soc_pkg.sv
// Shared SoC declarations used by the CSR bridge.
package soc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } csr_br_state_t;

  // Wide enough for any timeout in 1..65535.
  localparam int unsigned CSR_BR_TMO_W = $clog2(65536);

endpackage

// File: rtl/soc_csr_bridge.sv
// Bridge from the SoC register bus to a PeakRDL cpuif: one outstanding
// access, stall-aware issue, bounded response wait, sticky error capture.
module soc_csr_bridge
  import soc_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned BUS_AW    = 32,
  parameter int unsigned CSR_AW    = 8,
  parameter int unsigned TMO_CYC   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              bus_vld,
  input  logic [DW/8-1:0]   bus_we,
  input  logic [BUS_AW-1:0] bus_addr,
  input  logic [DW-1:0]     bus_wdat,
  output logic              bus_rdy,
  output logic [DW-1:0]     bus_rdat,
  output logic              cpuif_req,
  output logic              cpuif_req_is_wr,
  output logic [CSR_AW-1:0] cpuif_addr,
  output logic [DW-1:0]     cpuif_wr_data,
  output logic [DW-1:0]     cpuif_wr_biten,
  input  logic              cpuif_req_stall_wr,
  input  logic              cpuif_req_stall_rd,
  input  logic              cpuif_rd_ack,
  input  logic              cpuif_rd_err,
  input  logic              cpuif_wr_ack,
  input  logic              cpuif_wr_err,
  input  logic [DW-1:0]     cpuif_rd_data,
  output logic              err_flag,
  output logic [BUS_AW-1:0] err_addr,
  input  logic              err_clr
);

  localparam logic [DW-1:0]           ERR_DW  = DW'(ERR_RDATA);
  localparam logic [CSR_BR_TMO_W-1:0] TMO_LIM = CSR_BR_TMO_W'(TMO_CYC);

  csr_br_state_t           state, state_nxt;
  logic [BUS_AW-1:0]       addr_q;
  logic [DW/8-1:0]         we_q;
  logic [DW-1:0]           wdat_q;
  logic [DW-1:0]           rdat_q;
  logic [CSR_BR_TMO_W-1:0] cnt;

  logic is_wr, stall, ack, ack_err, tmo, done, done_err;

  assign is_wr   = |we_q;
  assign stall   = is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd;
  assign ack     = is_wr ? cpuif_wr_ack : cpuif_rd_ack;
  assign ack_err = is_wr ? cpuif_wr_err : cpuif_rd_err;
  assign tmo     = (cnt == TMO_LIM);

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state; an ack is only honoured when it coincides with acceptance
  // or arrives in WAIT, and it takes priority over a timeout in that cycle.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    done_err  = 1'b0;
    unique case (state)
      IDLE: if (bus_vld) state_nxt = ISSUE;
      ISSUE: begin
        if (!stall && ack) begin
          state_nxt = RESP;
          done      = 1'b1;
          done_err  = ack_err;
        end else if (tmo) begin
          state_nxt = RESP;
          done      = 1'b1;
          done_err  = 1'b1;
        end else if (!stall) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (ack) begin
          state_nxt = RESP;
          done      = 1'b1;
          done_err  = ack_err;
        end else if (tmo) begin
          state_nxt = RESP;
          done      = 1'b1;
          done_err  = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, timeout counter and response data.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_q <= '0;
      we_q   <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      cnt    <= '0;
    end else begin
      if (state == IDLE && bus_vld) begin
        addr_q <= bus_addr;
        we_q   <= bus_we;
        wdat_q <= bus_wdat;
        cnt    <= '0;
      end else if (state == ISSUE || state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (done) rdat_q <= done_err ? ERR_DW : cpuif_rd_data;
    end
  end

  // Sticky error flag; a simultaneous clear loses to a new error and the
  // new address is taken as the first error after that clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (done && done_err) begin
      err_flag <= 1'b1;
      if (!err_flag || err_clr) err_addr <= addr_q;
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end
  end

  // Byte enables expanded to per-bit enables.
  always_comb begin
    cpuif_wr_biten = '0;
    for (int unsigned i = 0; i < DW / 8; i++) begin
      cpuif_wr_biten[i*8 +: 8] = {8{we_q[i]}};
    end
  end

  assign bus_rdy         = (state == RESP);
  assign bus_rdat        = (state == RESP && !is_wr) ? rdat_q : '0;
  assign cpuif_req       = (state == ISSUE);
  assign cpuif_req_is_wr = (state == ISSUE) && is_wr;
  assign cpuif_addr      = {addr_q[CSR_AW-1:2], 2'b00};
  assign cpuif_wr_data   = wdat_q;

`ifdef SIM_ONLY
  // Requester must hold bus_vld until bus_rdy.
  always_ff @(posedge clk) begin
    if (arst_n && (state == ISSUE || state == WAIT) && !bus_vld)
      $error("soc_csr_bridge: bus_vld dropped before bus_rdy");
  end
`endif

endmodule

// File: tb/tb_soc_csr_bridge.sv
// Self-checking bench for soc_csr_bridge: directed scenarios plus a random
// back-to-back run scored against a cycle-count/flag model.
module tb_soc_csr_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        bus_vld;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr, bus_wdat, bus_rdat;
  logic        bus_rdy;
  logic        cpuif_req, cpuif_req_is_wr;
  logic [7:0]  cpuif_addr;
  logic [31:0] cpuif_wr_data, cpuif_wr_biten, cpuif_rd_data;
  logic        stall_wr, stall_rd, rd_ack, rd_err, wr_ack, wr_err;
  logic        err_flag, err_clr;
  logic [31:0] err_addr;

  int checks = 0;
  int passed = 0;

  soc_csr_bridge #(
    .DW(32), .BUS_AW(32), .CSR_AW(8), .TMO_CYC(TMO), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .bus_vld(bus_vld), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdat(bus_wdat),
    .bus_rdy(bus_rdy), .bus_rdat(bus_rdat),
    .cpuif_req(cpuif_req), .cpuif_req_is_wr(cpuif_req_is_wr), .cpuif_addr(cpuif_addr),
    .cpuif_wr_data(cpuif_wr_data), .cpuif_wr_biten(cpuif_wr_biten),
    .cpuif_req_stall_wr(stall_wr), .cpuif_req_stall_rd(stall_rd),
    .cpuif_rd_ack(rd_ack), .cpuif_rd_err(rd_err),
    .cpuif_wr_ack(wr_ack), .cpuif_wr_err(wr_err), .cpuif_rd_data(cpuif_rd_data),
    .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference timing: the ack lands (stall + delay) cycles into the access
  // and bus_rdy follows two cycles after bus_vld plus that; no ack inside
  // the timeout window means bus_rdy at TMO + 2 with an error.
  function automatic int exp_rdy(int stall, int delay, bit ack_en);
    return (ack_en && (stall + delay <= TMO)) ? stall + delay + 2 : TMO + 2;
  endfunction

  function automatic bit exp_err(int stall, int delay, bit ack_en, bit ack_err);
    return !(ack_en && (stall + delay <= TMO)) || ack_err;
  endfunction

  function automatic logic [31:0] exp_biten(logic [3:0] we);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) if (we[i]) b[i*8 +: 8] = 8'hFF;
    return b;
  endfunction

  task automatic clear_cpuif();
    stall_wr = 0; stall_rd = 0; rd_ack = 0; rd_err = 0; wr_ack = 0; wr_err = 0;
    cpuif_rd_data = '0;
  endtask

  // Drives one bus access and emulates the cpuif: stalls the first `stall`
  // request cycles, acks `delay` cycles after acceptance. Observations only.
  task automatic run_access(
    input  logic [3:0]  we,
    input  logic [31:0] addr, wdat, rdata,
    input  int          stall, delay,
    input  bit          ack_en, ack_err, noise,
    input  int          clr_cyc,
    output int          rdy_cyc,
    output logic [31:0] rdat,
    output int          req_cnt,
    output logic [7:0]  s_addr,
    output logic [31:0] s_biten, s_wdat,
    output logic        s_iswr, rdy0, leak
  );
    int cyc, acc_cyc;
    bit acc, is_wr;
    is_wr = (we != 4'h0);
    rdy_cyc = -1; rdat = '0; req_cnt = 0; s_addr = '0; s_biten = '0; s_wdat = '0;
    s_iswr = 0; leak = 0; acc = 0; acc_cyc = 0;
    @(posedge clk); #1;
    rdy0 = bus_rdy;
    if (bus_rdat !== '0) leak = 1;
    bus_vld = 1; bus_we = we; bus_addr = addr; bus_wdat = wdat;
    clear_cpuif();
    err_clr = (clr_cyc == 0);
    cyc = 0;
    while (rdy_cyc < 0 && cyc < TMO + 12) begin
      @(posedge clk); #1;
      cyc++;
      clear_cpuif();
      err_clr = (clr_cyc == cyc);
      if (bus_rdy) begin
        rdy_cyc = cyc;
        rdat = bus_rdat;
        bus_vld = 0;
      end else begin
        if (bus_rdat !== '0) leak = 1;
        if (noise) begin
          cpuif_rd_data = $urandom;
          if (is_wr) begin
            stall_rd = 1'($urandom); rd_ack = 1'($urandom); rd_err = 1'($urandom);
          end else begin
            stall_wr = 1'($urandom); wr_ack = 1'($urandom); wr_err = 1'($urandom);
          end
        end
        if (cpuif_req) begin
          if (req_cnt == 0) begin
            s_addr = cpuif_addr; s_biten = cpuif_wr_biten; s_wdat = cpuif_wr_data;
            s_iswr = cpuif_req_is_wr;
          end
          req_cnt++;
          if (!acc) begin
            if (req_cnt <= stall) begin
              if (is_wr) stall_wr = 1; else stall_rd = 1;
            end else begin
              if (is_wr) stall_wr = 0; else stall_rd = 0;
              acc = 1; acc_cyc = cyc;
            end
          end
        end
        if (ack_en && acc && cyc == acc_cyc + delay) begin
          if (is_wr) begin wr_ack = 1; wr_err = ack_err; end
          else begin rd_ack = 1; rd_err = ack_err; cpuif_rd_data = rdata; end
        end
      end
    end
    bus_vld = 0; bus_we = '0;
    err_clr = 0;
    clear_cpuif();
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; err_clr = 1;
    @(posedge clk); #1; err_clr = 0;
  endtask

  task automatic test_reset();
    arst_n = 0; bus_vld = 0; bus_we = '0; bus_addr = '0; bus_wdat = '0; err_clr = 0;
    clear_cpuif();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_rdy !== 1'b0) $display("FAIL reset_bus_rdy: got %b want 0", bus_rdy); else passed++;
    checks++; if (bus_rdat !== '0) $display("FAIL reset_bus_rdat: got %h want 0", bus_rdat); else passed++;
    checks++; if ({cpuif_req, cpuif_req_is_wr} !== 2'b00) $display("FAIL reset_cpuif_req: got %b want 00", {cpuif_req, cpuif_req_is_wr}); else passed++;
    checks++; if ({cpuif_addr, cpuif_wr_data, cpuif_wr_biten} !== '0) $display("FAIL reset_cpuif_data: got %h/%h/%h want 0", cpuif_addr, cpuif_wr_data, cpuif_wr_biten); else passed++;
    checks++; if ({err_flag, err_addr} !== '0) $display("FAIL reset_err: got flag %b addr %h want 0", err_flag, err_addr); else passed++;
    @(negedge clk); arst_n = 1;
  endtask

  task automatic test_read_basic();
    int rdy, rq; logic [31:0] rd, bi, wd; logic [7:0] sa; logic iw, r0, lk;
    run_access(4'h0, 32'h10, 32'h0, 32'h1234_5678, 0, 1, 1, 0, 0, -1, rdy, rd, rq, sa, bi, wd, iw, r0, lk);
    checks++; if (rdy !== 3) $display("FAIL read_rdy_cycle: got %0d want 3", rdy); else passed++;
    checks++; if (rd !== 32'h1234_5678) $display("FAIL read_rdat: got %h want 12345678", rd); else passed++;
    checks++; if (err_flag !== 1'b0) $display("FAIL read_err_flag: got %b want 0", err_flag); else passed++;
    checks++; if (sa !== 8'h10 || iw !== 1'b0) $display("FAIL read_cpuif_addr_dir: got %h/%b want 10/0", sa, iw); else passed++;
    run_access(4'h0, 32'h0000_0107, 32'h0, 32'hCAFE_0001, 0, 0, 1, 0, 0, -1, rdy, rd, rq, sa, bi, wd, iw, r0, lk);
    checks++; if (rdy !== 2) $display("FAIL read_same_cycle_ack_rdy: got %0d want 2", rdy); else passed++;
    checks++; if (rd !== 32'hCAFE_0001 || sa !== 8'h04) $display("FAIL read_same_cycle_data: got %h/%h want cafe0001/04", rd, sa); else passed++;
  endtask

  task automatic test_write_stall();
    int rdy, rq; logic [31:0] rd, bi, wd; logic [7:0] sa; logic iw, r0, lk;
    run_access(4'b0101, 32'h18, 32'hAABB_CCDD, 32'h0, 4, 1, 1, 0, 0, -1, rdy, rd, rq, sa, bi, wd, iw, r0, lk);
    checks++; if (rq !== 5) $display("FAIL write_req_cycles: got %0d want 5", rq); else passed++;
    checks++; if (bi !== 32'h00FF_00FF) $display("FAIL write_biten: got %h want 00ff00ff", bi); else passed++;
    checks++; if (wd !== 32'hAABB_CCDD || iw !== 1'b1) $display("FAIL write_data_dir: got %h/%b want aabbccdd/1", wd, iw); else passed++;
    checks++; if (rdy !== 7) $display("FAIL write_rdy_cycle: got %0d want 7", rdy); else passed++;
  endtask

  task automatic test_timeout();
    int rdy, rq; logic [31:0] rd, bi, wd; logic [7:0] sa; logic iw, r0, lk;
    pulse_clr();
    run_access(4'h0, 32'h44, 32'h0, 32'h0, 0, 0, 0, 0, 0, -1, rdy, rd, rq, sa, bi, wd, iw, r0, lk);
    checks++; if (rdy !== TMO + 2) $display("FAIL timeout_rdy_cycle: got %0d want %0d", rdy, TMO + 2); else passed++;
    checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL timeout_rdat: got %h want deadbeef", rd); else passed++;
    checks++; if (err_flag !== 1'b1 || err_addr !== 32'h44) $display("FAIL timeout_err: got %b/%h want 1/44", err_flag, err_addr); else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_ack = 1; rd_err = 1; cpuif_rd_data = 32'h5555_5555;
    @(posedge clk); #1;
    clear_cpuif();
    checks++; if (bus_rdy !== 1'b0 || cpuif_req !== 1'b0) $display("FAIL late_ack_ignored: got rdy %b req %b want 0/0", bus_rdy, cpuif_req); else passed++;
    run_access(4'h0, 32'h48, 32'h0, 32'h0BAD_F00D, 0, 0, 1, 0, 0, -1, rdy, rd, rq, sa, bi, wd, iw, r0, lk);
    checks++; if (rdy !== 2 || rd !== 32'h0BAD_F00D) $display("FAIL after_timeout_read: got %0d/%h want 2/0badf00d", rdy, rd); else passed++;
    checks++; if (err_addr !== 32'h44) $display("FAIL after_timeout_err_addr: got %h want 44", err_addr); else passed++;
  endtask

  task automatic test_errors();
    int rdy, rq; logic [31:0] rd, bi, wd; logic [7:0] sa; logic iw, r0, lk;
    pulse_clr();
    checks++; if (err_flag !== 1'b0) $display("FAIL clr_idle: got %b want 0", err_flag); else passed++;
    run_access(4'h0, 32'h20, 32'h0, 32'h1111_2222, 0, 1, 1, 1, 0, -1, rdy, rd, rq, sa, bi, wd, iw, r0, lk);
    checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rd_err_rdat: got %h want deadbeef", rd); else passed++;
    checks++; if (err_flag !== 1'b1 || err_addr !== 32'h20) $display("FAIL rd_err_capture: got %b/%h want 1/20", err_flag, err_addr); else passed++;
    run_access(4'hF, 32'h24, 32'h3333_4444, 32'h0, 1, 1, 1, 1, 0, -1, rdy, rd, rq, sa, bi, wd, iw, r0, lk);
    checks++; if (rdy !== 4) $display("FAIL wr_err_completes: got %0d want 4", rdy); else passed++;
    checks++; if (err_addr !== 32'h20) $display("FAIL first_error_wins: got %h want 20", err_addr); else passed++;
    run_access(4'h0, 32'h30, 32'h0, 32'h0, 0, 1, 1, 1, 0, 2, rdy, rd, rq, sa, bi, wd, iw, r0, lk);
    checks++; if (err_flag !== 1'b1 || err_addr !== 32'h30) $display("FAIL clr_vs_set: got %b/%h want 1/30", err_flag, err_addr); else passed++;
    pulse_clr();
    checks++; if (err_flag !== 1'b0 || err_addr !== 32'h30) $display("FAIL clr_keeps_addr: got %b/%h want 0/30", err_flag, err_addr); else passed++;
  endtask

  task automatic test_reset_mid();
    int rdy, rq, seen; logic [31:0] rd, bi, wd; logic [7:0] sa; logic iw, r0, lk;
    run_access(4'h0, 32'h50, 32'h0, 32'h0, 0, 0, 1, 1, 0, -1, rdy, rd, rq, sa, bi, wd, iw, r0, lk);
    checks++; if (err_flag !== 1'b1) $display("FAIL reset_mid_precond_flag: got %b want 1", err_flag); else passed++;
    @(posedge clk); #1;
    bus_vld = 1; bus_we = 4'hF; bus_addr = 32'h3C; bus_wdat = 32'h7777_8888;
    @(posedge clk); #1;
    checks++; if (cpuif_req !== 1'b1 || cpuif_addr !== 8'h3C) $display("FAIL reset_mid_issue: got %b/%h want 1/3c", cpuif_req, cpuif_addr); else passed++;
    @(posedge clk); #1;
    arst_n = 0;
    #1;
    checks++; if ({bus_rdy, bus_rdat, cpuif_req, cpuif_req_is_wr} !== '0) $display("FAIL reset_mid_bus: got %b/%h/%b%b want 0", bus_rdy, bus_rdat, cpuif_req, cpuif_req_is_wr); else passed++;
    checks++; if ({cpuif_addr, cpuif_wr_data, cpuif_wr_biten} !== '0) $display("FAIL reset_mid_cpuif: got %h/%h/%h want 0", cpuif_addr, cpuif_wr_data, cpuif_wr_biten); else passed++;
    checks++; if ({err_flag, err_addr} !== '0) $display("FAIL reset_mid_err: got %b/%h want 0", err_flag, err_addr); else passed++;
    bus_vld = 0; bus_we = '0;
    wr_ack = 1;
    @(posedge clk); #3;
    arst_n = 1;
    wr_ack = 0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus_rdy) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL reset_mid_no_rdy: got %0d pulses want 0", seen); else passed++;
    run_access(4'h0, 32'h14, 32'h0, 32'h2468_ACE0, 0, 1, 1, 0, 0, -1, rdy, rd, rq, sa, bi, wd, iw, r0, lk);
    checks++; if (rdy !== 3 || rd !== 32'h2468_ACE0) $display("FAIL reset_mid_recover: got %0d/%h want 3/2468ace0", rdy, rd); else passed++;
  endtask

  task automatic test_back_to_back();
    int rdy, rq, stall, delay, er, clr_cyc;
    logic [31:0] rd, bi, wd, addr, wdat, rdata;
    logic [7:0] sa; logic iw, r0, lk;
    logic [3:0] we;
    bit ack_en, ack_err, ee, m_flag;
    logic [31:0] m_addr;
    m_flag = 0; m_addr = '0;
    for (int n = 0; n < 100; n++) begin
      we      = 1'($urandom) ? 4'($urandom) : 4'h0;
      addr    = $urandom; wdat = $urandom; rdata = $urandom;
      stall   = int'($urandom_range(0, 5));
      delay   = int'($urandom_range(0, 5));
      ack_en  = ($urandom % 16) != 0;
      ack_err = ($urandom % 8) == 0;
      er      = exp_rdy(stall, delay, ack_en);
      ee      = exp_err(stall, delay, ack_en, ack_err);
      clr_cyc = (($urandom % 6) == 0) ? int'($urandom_range(0, er - 1)) : -1;
      run_access(we, addr, wdat, rdata, stall, delay, ack_en, ack_err, 1, clr_cyc,
                 rdy, rd, rq, sa, bi, wd, iw, r0, lk);
      if (clr_cyc >= 0 && clr_cyc < er - 1) m_flag = 0;
      if (ee) begin
        if (!m_flag || clr_cyc == er - 1) m_addr = addr;
        m_flag = 1;
      end else if (clr_cyc == er - 1) begin
        m_flag = 0;
      end
      checks++; if (rdy !== er) $display("FAIL b2b_rdy_cycle[%0d]: got %0d want %0d", n, rdy, er); else passed++;
      checks++; if (r0 !== 1'b0 || lk !== 1'b0) $display("FAIL b2b_single_rdy[%0d]: got extra rdy %b rdat leak %b want 0/0", n, r0, lk); else passed++;
      checks++; if (rq !== ((stall < TMO ? stall : TMO) + 1)) $display("FAIL b2b_req_cycles[%0d]: got %0d want %0d", n, rq, (stall < TMO ? stall : TMO) + 1); else passed++;
      checks++; if (sa !== {addr[7:2], 2'b00} || iw !== (we != 4'h0)) $display("FAIL b2b_cpuif_addr[%0d]: got %h/%b want %h/%b", n, sa, iw, {addr[7:2], 2'b00}, we != 4'h0); else passed++;
      if (we != 4'h0) begin
        checks++; if (bi !== exp_biten(we) || wd !== wdat) $display("FAIL b2b_write_data[%0d]: got %h/%h want %h/%h", n, bi, wd, exp_biten(we), wdat); else passed++;
      end else begin
        checks++; if (rd !== (ee ? 32'hDEAD_BEEF : rdata)) $display("FAIL b2b_read_data[%0d]: got %h want %h", n, rd, ee ? 32'hDEAD_BEEF : rdata); else passed++;
      end
      checks++; if (err_flag !== m_flag || err_addr !== m_addr) $display("FAIL b2b_err[%0d]: got %b/%h want %b/%h", n, err_flag, err_addr, m_flag, m_addr); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_timeout();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/soc_csr_bridge.md
# soc_csr_bridge

Parametrised bridge between the SoC register bus and a PeakRDL-generated CSR block's cpuif. It honours the cpuif stall and ack signals and inserts bus wait states until the access completes. It bounds every access with a response timeout and reports errors (cpuif `rd_err`/`wr_err` or timeout) through a sticky status flag with captured address. It sits between the SoC interconnect slave port and each `csr` instance, one bridge per CSR region.

## Interface
- `DW`, default 32: data width; must be a multiple of 8.
- `BUS_AW`, default 32: bus byte-address width.
- `CSR_AW`, default 8: cpuif byte-address width; `cpuif_addr = {bus_addr[CSR_AW-1:2], 2'b00}`.
- `TMO_CYC`, default 255: response timeout in cycles; legal range 1..65535.
- `ERR_RDATA`, default `32'hDEAD_BEEF`: read data returned on error, zero-extended or truncated to `DW`.

Ports:
- `clk`  in  1  single clock.
- `arst_n`  in  1  asynchronous, active-low reset.
- `bus_vld`  in  1  request valid; held until `bus_rdy`.
- `bus_we`  in  DW/8  byte write enables; all-zero means read.
- `bus_addr`  in  BUS_AW  byte address.
- `bus_wdat`  in  DW  write data.
- `bus_rdy`  out  1  one-cycle completion pulse.
- `bus_rdat`  out  DW  read data; valid only while `bus_rdy` is high on a read.
- `cpuif_req`, `cpuif_req_is_wr`  out  1  cpuif request and direction.
- `cpuif_addr`  out  CSR_AW  word-aligned cpuif address.
- `cpuif_wr_data`, `cpuif_wr_biten`  out  DW  write data; per-byte bit enables expanded from `bus_we`.
- `cpuif_req_stall_wr`, `cpuif_req_stall_rd`  in  1  cpuif stall, per direction.
- `cpuif_rd_ack`, `cpuif_rd_err`, `cpuif_wr_ack`, `cpuif_wr_err`  in  1  cpuif completion and error.
- `cpuif_rd_data`  in  DW  cpuif read data.
- `err_flag`  out  1  sticky error flag.
- `err_addr`  out  BUS_AW  byte address of the first error since the last clear.
- `err_clr`  in  1  clears `err_flag`.

## Operation
- States:
  - IDLE: `bus_vld` high → latch addr, we, wdat; go to ISSUE.
  - ISSUE: `cpuif_req` high while the stall signal for the current direction is high. Request accepted (req & !stall) → WAIT; an ack in the same cycle goes directly to RESP.
  - WAIT: `cpuif_req` low. Matching-direction ack → capture `rd_data` and err → RESP.
  - RESP: `bus_rdy` high for exactly one cycle → IDLE.
- Timeout counter:
  - Cleared on entering ISSUE; increments in ISSUE and WAIT.
  - Reaching `TMO_CYC` forces RESP with error; `bus_rdat = ERR_RDATA`, and `cpuif_req` drops.
- Errors and read data:
  - On error (cpuif err or timeout), read data is `ERR_RDATA`; a write is reported complete regardless.
  - `err_flag` sets on any error. `err_addr` is captured only when `err_flag` was clear (first error wins).
  - `err_clr` and a new error in the same cycle: the set wins, and `err_addr` loads the new address.
- Ack handling:
  - Acks received in IDLE, or with the wrong direction, are ignored; this includes late acks after a timeout.
  - Only the first ack per access is used.
- `bus_vld` dropping before `bus_rdy` is a protocol violation. The access still completes; under `SIM_ONLY` it is flagged with `$error`.
- `bus_rdat` is zero outside RESP.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0; `err_addr` 0.
- `arst_n` asserted mid-access aborts immediately; no `bus_rdy` is issued.
- Latency from `bus_vld` (cycle 0) with no stall:
  - Ack in the same cycle as req: `bus_rdy` at cycle 2.
  - Ack one cycle after req (PeakRDL registered): `bus_rdy` at cycle 3.
- Each stall cycle adds 1 cycle.
- Back-to-back: a new `bus_vld` is sampled in IDLE, the cycle after `bus_rdy`. Throughput is at most one access per 3 cycles.
- Timeout: `bus_rdy` at cycle `TMO_CYC + 2` after `bus_vld` when no ack arrives.

## Structure
- Shared `soc_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} csr_br_state_t`
  - `localparam` `CSR_BR_TMO_W = $clog2(65536)`
- No sub-module: FSM, counter, and error capture stay in the single module. The existing `csr` instance is connected by the parent.

## Test plan
- Read at 0x10, cpuif acks 1 cycle after req with data 0x1234_5678 → `bus_rdy` at cycle 3, `bus_rdat` = 0x1234_5678, `err_flag` = 0.
- Write `bus_we` = 4'b0101, wdat 0xAABB_CCDD, stall_wr high for 4 cycles → `cpuif_req` held 5 cycles, `cpuif_wr_biten` = 0x00FF_00FF, `bus_rdy` at cycle 7.
- Read with no ack, `TMO_CYC` = 8 → `bus_rdy` at cycle 10, `rdat` = 0xDEAD_BEEF, `err_flag` = 1, `err_addr` = the bus address. A late ack 2 cycles later has no effect.
- `rd_err` on read of 0x20, then `wr_err` on 0x24 → `err_addr` stays 0x20. `err_clr` and an error in the same cycle → flag stays 1, `err_addr` = new address.
- `arst_n` pulsed low during WAIT → all outputs 0 immediately. A subsequent read completes normally.
- 100 random back-to-back accesses with random stall and ack delays (0–5 cycles) against a scoreboard model → every access completes exactly once with correct data.
